imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, parametrised RISC-V immediate generator for the decode stage. Accepts one 32-bit instruction per cycle over a valid/ready handshake. Extracts and sign-extends the I/S/B/U/J immediate to XLEN bits and applies a configurable PC-relative bias. Delivers the result through a two-entry skid buffer, so throughput stays at one instruction per cycle under backpressure and all paths are fully registered.

## Interface
Parameters:
- XLEN, 32: output immediate width; legal values 32 or 64.
- BRANCH_BIAS, 8: constant subtracted from B- and J-type immediates (pipeline PC compensation).
- UPPER_BIAS, 4: constant subtracted from LUI/AUIPC immediates.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all buffered entries; the input offered in the same cycle is dropped.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  block can accept; equals !skid_valid, forced 0 while rst=1.
- in_instr  in  32  raw instruction.
- out_valid  out  1  out_imm/out_fmt valid.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended, biased immediate.
- out_fmt  out  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J.

## Operation
- Opcode decode on in_instr[6:0]:
  - 0010011, 0000011, 1100111 → I: sext(instr[31:20]).
  - 0100011 → S: sext({instr[31:25], instr[11:7]}).
  - 1100011 → B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}) − BRANCH_BIAS.
  - 0110111, 0010111 → U: sext({instr[31:12], 12'b0}) − UPPER_BIAS.
  - 1101111 → J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}) − BRANCH_BIAS.
  - Any other opcode → imm 0, fmt 0, bias not applied.
- Sign extension is from instr[31] to XLEN. For XLEN=64, U-type extends bit 31.
- Bias subtraction is modulo 2^XLEN; wrap-around is allowed and is not flagged.
- Immediate computation is combinational from in_instr. The result is captured into the main register or the skid register.
- Buffer state machine (occupancy), transitions on the clk edge:
  - EMPTY: out_valid=0.
    - Input accepted → ONE.
  - ONE: out_valid=1, main register driven.
    - Accept input and output together → ONE; main register reloads.
    - Output only → EMPTY.
    - Input only → FULL; the new entry goes to the skid register.
  - FULL: in_ready=0.
    - Output accepted → ONE; skid moves to main.
    - Otherwise hold.
- Ordering is strict FIFO; no entry is lost or duplicated.
- flush=1 → EMPTY next cycle, regardless of in_valid/out_ready. flush has priority over every other event.

## Timing
- Reset: on a clk edge with rst=1, state=EMPTY, out_valid=0, out_imm=0, out_fmt=0, skid cleared. in_ready=0 during reset and 1 in the first cycle after rst deasserts.
- Latency: an instruction accepted at edge N is presented on out_* after edge N (one cycle).
- Throughput: one per cycle while out_ready=1.
- in_ready depends only on registered state (no combinational path from out_ready).
- out_imm and out_fmt are stable while out_valid=1 and out_ready=0.
- rst asserted mid-transfer takes precedence over flush and over handshakes. Buffered data is discarded.

## Test plan
- Reset then I-type: in_instr=0xFFF00093 (addi x1,x0,-1) → next cycle out_valid=1, out_imm=0xFFFFFFFF (XLEN=64: 0xFFFFFFFFFFFFFFFF), out_fmt=1.
- S and B: 0x0020A423 (sw x2,8(x1)) → imm 8, fmt 2. Then 0x00000863 (beq +16) → imm 16−8=8, fmt 3. Issued back-to-back with out_ready=1 → consecutive output cycles.
- U/J with bias: 0x123450B7 (lui) → 0x12344FFC, fmt 4. 0x0000006F (jal +0) → 0xFFFFFFF8, fmt 5 (wrap-around).
- Unknown opcode 0x00000073 → imm 0, fmt 0.
- Backpressure: out_ready=0, present A, B, C on consecutive cycles. A appears on out_*, B is captured in skid, then in_ready=0 and C is held. Raise out_ready → A, B, C emerge in order on three consecutive cycles with no bubble after B.
- Flush/reset in FULL: flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, flushed input never appears. Repeating with rst=1 instead → all outputs 0.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the instruction supplier and the immediate consumer
// of imm_gen_pipe. The slave modport is the block's view; master is the peer's.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V I/S/B/U/J immediate generator with PC-relative bias, delivered through
// a two-entry skid buffer (main + skid register) so every output is registered.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int BRANCH_BIAS = 8,
  parameter int UPPER_BIAS  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
    FMT_B    = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_e;

  localparam logic [XLEN-1:0] BR_BIAS = XLEN'(BRANCH_BIAS);
  localparam logic [XLEN-1:0] UP_BIAS = XLEN'(UPPER_BIAS);

  state_e          state_q, state_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  fmt_e            main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;

  logic [31:0]     dec_raw;
  logic [XLEN-1:0] dec_bias;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            in_ready_w;
  logic            out_valid_w;
  logic            accept_in;
  logic            accept_out;

  // Every immediate is first formed as a 32-bit value whose bit 31 is the
  // instruction sign, then widened as signed so XLEN=64 extends bit 31.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    dec_raw  = '0;
    dec_bias = '0;
    dec_fmt  = FMT_NONE;
    case (bus.in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_raw = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        dec_fmt = FMT_I;
      end
      7'b0100011: begin
        dec_raw = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        dec_raw  = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                    bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
        dec_bias = BR_BIAS;
        dec_fmt  = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        dec_raw  = {bus.in_instr[31:12], 12'b0};
        dec_bias = UP_BIAS;
        dec_fmt  = FMT_U;
      end
      7'b1101111: begin
        dec_raw  = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                    bus.in_instr[20], bus.in_instr[30:21], 1'b0};
        dec_bias = BR_BIAS;
        dec_fmt  = FMT_J;
      end
      default: ;
    endcase
    dec_imm = XLEN'($signed(dec_raw)) - dec_bias;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge regardless of block order.
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Data registers are reset too, so out_imm/out_fmt read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_imm_q <= '0;
      main_fmt_q <= FMT_NONE;
      skid_imm_q <= '0;
      skid_fmt_q <= FMT_NONE;
    end else begin
      main_imm_q <= main_imm_d;
      main_fmt_q <= main_fmt_d;
      skid_imm_q <= skid_imm_d;
      skid_fmt_q <= skid_fmt_d;
    end
  end

  always_comb begin
    accept_in  = bus.in_valid && in_ready_w;
    accept_out = out_valid_w && bus.out_ready;
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_fmt_d = main_fmt_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept_in) begin
          state_d    = ONE;
          main_imm_d = dec_imm;
          main_fmt_d = dec_fmt;
        end
        ONE: begin
          if (accept_in && accept_out) begin
            main_imm_d = dec_imm;
            main_fmt_d = dec_fmt;
          end else if (accept_out) begin
            state_d = EMPTY;
          end else if (accept_in) begin
            state_d    = FULL;
            skid_imm_d = dec_imm;
            skid_fmt_d = dec_fmt;
          end
        end
        FULL: if (accept_out) begin
          state_d    = ONE;
          main_imm_d = skid_imm_q;
          main_fmt_d = skid_fmt_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready looks only at registered occupancy (plus reset), never out_ready.
  always_comb begin
    in_ready_w  = (state_q != FULL) && !rst;
    out_valid_w = (state_q != EMPTY);
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_imm   = main_imm_q;
  assign bus.out_fmt   = main_fmt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (XLEN=32): decode of every format, bias
// wrap-around, back-to-back flow, skid backpressure, flush and reset in FULL.
module tb_imm_gen_pipe;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_checks   = 0;
  int   n_failures = 0;

  imm_gen_pipe_if #(.XLEN(XLEN)) bus ();

  imm_gen_pipe #(.XLEN(XLEN), .BRANCH_BIAS(8), .UPPER_BIAS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there as well.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] imm,
                            input logic [2:0] fmt);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
    if (v) begin
      check({tag, ".imm"}, 64'(bus.out_imm), 64'(imm));
      check({tag, ".fmt"}, 64'(bus.out_fmt), 64'(fmt));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr);
    bus.in_valid = v;
    bus.in_instr = instr;
  endtask

  task automatic fill_full(input logic [31:0] a, input logic [31:0] b);
    bus.out_ready = 1'b0;
    drive(1'b1, a);
    step();
    drive(1'b1, b);
    step();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    string       tag;
  } vec_t;

  vec_t stream[6];

  initial begin
    stream[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, "addi_m1"};
    stream[1] = '{32'h0020A423, 32'h00000008, 3'd2, "sw_8"};
    stream[2] = '{32'h00000863, 32'h00000008, 3'd3, "beq_16"};
    stream[3] = '{32'h123450B7, 32'h12344FFC, 3'd4, "lui"};
    stream[4] = '{32'h0000006F, 32'hFFFFFFF8, 3'd5, "jal_0"};
    stream[5] = '{32'h00000073, 32'h00000000, 3'd0, "ecall"};

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst.in_ready", 64'(bus.in_ready), 64'd0);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.out_imm", 64'(bus.out_imm), 64'd0);
    check("rst.out_fmt", 64'(bus.out_fmt), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", 64'(bus.in_ready), 64'd1);

    // Back-to-back stream with out_ready held high: one result per cycle.
    foreach (stream[i]) begin
      drive(1'b1, stream[i].instr);
      step();
      expect_out(stream[i].tag, 1'b1, stream[i].imm, stream[i].fmt);
      check({stream[i].tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    end
    drive(1'b0, '0);
    step();
    expect_out("drain", 1'b0, '0, '0);

    // Backpressure: A shows, B goes to skid, C is held off.
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00500093);
    step();
    expect_out("bp.A", 1'b1, 32'd5, 3'd1);
    check("bp.A.in_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 32'h00C00093);
    step();
    expect_out("bp.A_hold", 1'b1, 32'd5, 3'd1);
    check("bp.full.in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'h0000006F);
    step();
    expect_out("bp.A_hold2", 1'b1, 32'd5, 3'd1);
    check("bp.full2.in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step();
    expect_out("bp.B", 1'b1, 32'd12, 3'd1);
    check("bp.B.in_ready", 64'(bus.in_ready), 64'd1);
    step();
    expect_out("bp.C", 1'b1, 32'hFFFFFFF8, 3'd5);
    drive(1'b0, '0);
    step();
    expect_out("bp.drain", 1'b0, '0, '0);

    // Flush in FULL drops both buffered entries and the input offered with it.
    fill_full(32'h00500093, 32'h00C00093);
    check("fl.full.in_ready", 64'(bus.in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h123450B7);
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    expect_out("fl.empty", 1'b0, '0, '0);
    check("fl.in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    step();
    expect_out("fl.no_ghost", 1'b0, '0, '0);

    // Reset in FULL wins over flush and handshakes and zeroes the outputs.
    fill_full(32'hFFF00093, 32'h0020A423);
    rst   = 1'b1;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h00000863);
    step();
    check("rst2.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst2.out_imm", 64'(bus.out_imm), 64'd0);
    check("rst2.out_fmt", 64'(bus.out_fmt), 64'd0);
    check("rst2.in_ready", 64'(bus.in_ready), 64'd0);
    rst   = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0);
    #1;
    check("rst2.post.in_ready", 64'(bus.in_ready), 64'd1);
    step();
    expect_out("rst2.no_ghost", 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
